// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS transfer out, one completion back.
// Optional macro APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES consecutive PREADY-low cycles.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL high, PENABLE low, exactly one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY (or timeout)
// RESP   | completion held on rsp_* until rsp_ready
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                psel_nxt;
  logic                penable_nxt;
  logic                pwrite_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt;
  logic                rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt;
  logic                timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_err_nxt;

  // Counter is held at zero outside ACCESS, so it is clear on every ACCESS entry.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state != ACCESS) begin
      tmo_cnt <= '0;
    end else if (!PREADY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign cmd_ready = (state == IDLE) && PRESETn;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rsp_err_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    psel_nxt      = PSEL;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_err_nxt   = rsp_err;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        // A PREADY on the timeout edge still counts as a normal completion.
        if (PREADY) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_nxt   = 1'b0;
`endif
          state_nxt     = RESP;
        end else if (timeout_hit) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_nxt   = 1'b1;
`endif
          state_nxt     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: timeline model of each transfer plus a wait-state APB responder.
// Expectations follow APB_MASTER_TIMEOUT_EN when the macro is defined for the build.
module tb_apb_master_bridge;

  localparam int TMO = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int   resp_w = 0;
  logic glitch = 1'b0;
  int   acc_cnt;
  logic [31:0] slave_mem [256];
  logic [31:0] model_mem [256];

  logic        m_act = 1'b0;
  int          m_a, m_w;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;

  task automatic check1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Responder: PREADY rises after resp_w low ACCESS cycles; optionally raises PREADY during SETUP too.
  initial begin
    PREADY = 1'b0;
    PRDATA = '0;
    acc_cnt = 0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) begin
        if (acc_cnt >= resp_w) begin
          PREADY = 1'b1;
          PRDATA = slave_mem[PADDR];
          if (PWRITE) slave_mem[PADDR] = PWDATA;
        end else begin
          PREADY = 1'b0;
          PRDATA = $urandom;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        PREADY  = glitch && PSEL;
        PRDATA  = $urandom;
      end
    end
  end

  // Model: a transfer accepted at edge a with w wait states shows PSEL after edges a..a+1+w,
  // PENABLE after a+1..a+1+w, and rsp_valid from a+2+w until the rsp_ready handshake.
  always @(negedge PCLK) begin
    int d, weff;
    logic er, e_psel, e_pen, e_rv;
    logic [31:0] e_rd;
    if (!PRESETn) begin
      m_act = 1'b0;
      check1("rst_psel", PSEL, 1'b0);
      check1("rst_penable", PENABLE, 1'b0);
      check1("rst_rsp_valid", rsp_valid, 1'b0);
      check1("rst_cmd_ready", cmd_ready, 1'b0);
      check1("rst_rsp_err", rsp_err, 1'b0);
    end else begin
      e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0; e_rd = '0; er = 1'b0; weff = m_w;
      if (m_act) begin
        d = cyc - m_a;
`ifdef APB_MASTER_TIMEOUT_EN
        if (m_w >= TMO) begin
          weff = TMO - 1;
          er   = 1'b1;
        end
`endif
        e_psel = (d <= weff + 1);
        e_pen  = (d >= 1) && (d <= weff + 1);
        e_rv   = (d >= weff + 2);
        e_rd   = (er || m_wr) ? 32'h0 : model_mem[m_addr];
      end
      check1("cmd_ready", cmd_ready, !m_act);
      check1("psel", PSEL, e_psel);
      check1("penable", PENABLE, e_pen);
      check1("rsp_valid", rsp_valid, e_rv);
      if (e_psel) begin
        check32("paddr", {24'h0, PADDR}, {24'h0, m_addr});
        check32("pwdata", PWDATA, m_wdata);
        check1("pwrite", PWRITE, m_wr);
      end
      if (e_rv) begin
        check32("rsp_rdata", rsp_rdata, e_rd);
        check1("rsp_err", rsp_err, er);
      end
      if (!m_act) begin
        if (cmd_valid) begin
          m_act   = 1'b1;
          m_a     = cyc + 1;
          m_w     = resp_w;
          m_wr    = cmd_write;
          m_addr  = cmd_addr;
          m_wdata = cmd_wdata;
        end
      end else if (e_rv && rsp_ready) begin
        if (m_wr && !er) model_mem[m_addr] = m_wdata;
        m_act = 1'b0;
      end
    end
  end

  task automatic run(input logic wr, input logic [7:0] ad, input logic [31:0] wd,
                     input int w, input int hold, input logic keep,
                     output logic [31:0] rd, output logic er, output int lat, output int acc);
    int n;
    resp_w = w; cmd_write = wr; cmd_addr = ad; cmd_wdata = wd; cmd_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (cmd_ready) break;
      n++;
      if (n > 100) begin
        tests++; fails++;
        $display("FAIL accept_timeout: cmd_ready low for %0d cycles, expected high", n);
        break;
      end
    end
    @(posedge PCLK); #2;
    acc = cyc;
    if (!keep) cmd_valid = 1'b0;
    lat = -1;
    n = 0;
    while (n < 200) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        lat = cyc - acc;
        break;
      end
      n++;
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: rsp_valid 0 after %0d cycles, expected 1", n);
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) @(negedge PCLK);
    @(posedge PCLK); #2;
    rsp_ready = 1'b1;
    @(posedge PCLK); #2;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, acc, rel, n;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = {4{i[7:0]}} ^ 32'h5A5A_5A5A;
      model_mem[i] = {4{i[7:0]}} ^ 32'h5A5A_5A5A;
    end
    PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h11;
    cmd_wdata = 32'h0000_1234; rsp_ready = 1'b0;
    repeat (3) @(posedge PCLK);
    #2;
    check1("lit_rst_psel", PSEL, 1'b0);
    check1("lit_rst_cmd_ready", cmd_ready, 1'b0);
    check32("lit_rst_paddr", {24'h0, PADDR}, 32'h0);
    check32("lit_rst_pwdata", PWDATA, 32'h0);
    check32("lit_rst_rdata", rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    rel = cyc;

    // held command goes in on the first edge after release, zero wait states
    run(1'b1, 8'h11, 32'h0000_1234, 0, 0, 1'b0, rd, er, lat, acc);
    check32("lit_accept_after_reset", 32'(acc), 32'(rel + 1));
    check32("lit_lat_w0", 32'(lat), 32'd2);

    run(1'b1, 8'hA5, 32'hDEAD_BEEF, 1, 0, 1'b0, rd, er, lat, acc);
    check32("lit_lat_w1", 32'(lat), 32'd3);
    check32("lit_wr_rdata", rd, 32'h0);
    check1("lit_wr_err", er, 1'b0);

    run(1'b0, 8'hA5, 32'h0, 1, 0, 1'b0, rd, er, lat, acc);
    check32("lit_rd_rdata", rd, 32'hDEAD_BEEF);
    check1("lit_rd_err", er, 1'b0);

    // backpressure with a new command already waiting
    run(1'b0, 8'h11, 32'h0, 2, 5, 1'b1, rd, er, lat, acc);
    check32("lit_bp_rdata", rd, 32'h0000_1234);
    check32("lit_lat_w2", 32'(lat), 32'd4);

    glitch = 1'b1;
    run(1'b1, 8'h20, 32'hCAFE_F00D, 2, 0, 1'b0, rd, er, lat, acc);
    glitch = 1'b0;
    check32("lit_setup_pready_ignored", 32'(lat), 32'd4);

    run(1'b0, 8'h33, 32'h0, 0, 1, 1'b0, rd, er, lat, acc);
    check32("lit_rd_preload", rd, 32'h6969_6969);

    // PREADY arrives on the 4th ACCESS cycle
    run(1'b0, 8'h20, 32'h0, TMO - 1, 0, 1'b0, rd, er, lat, acc);
    check32("lit_edge_rdata", rd, 32'hCAFE_F00D);
    check1("lit_edge_err", er, 1'b0);
    check32("lit_edge_lat", 32'(lat), 32'd5);

    run(1'b0, 8'hA5, 32'h0, 60, 0, 1'b0, rd, er, lat, acc);
`ifdef APB_MASTER_TIMEOUT_EN
    check1("lit_tmo_err", er, 1'b1);
    check32("lit_tmo_rdata", rd, 32'h0);
    check32("lit_tmo_lat", 32'(lat), 32'd5);
`else
    check1("lit_wait_err", er, 1'b0);
    check32("lit_wait_rdata", rd, 32'hDEAD_BEEF);
    check32("lit_wait_lat", 32'(lat), 32'd62);
`endif

    // reset during a wait state discards the write
    resp_w = 20; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'h1111_2222; cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (cmd_ready || n > 100) break;
      n++;
    end
    @(posedge PCLK); #2;
    cmd_valid = 1'b0;
    repeat (3) @(posedge PCLK);
    #2;
    check1("lit_mid_psel_before", PSEL, 1'b1);
    PRESETn = 1'b0;
    #1;
    check1("lit_mid_psel", PSEL, 1'b0);
    check1("lit_mid_penable", PENABLE, 1'b0);
    @(posedge PCLK); #2;
    PRESETn = 1'b1;
    #1;
    check1("lit_mid_cmd_ready", cmd_ready, 1'b1);
    repeat (30) @(posedge PCLK);
    #2;
    check1("lit_mid_no_rsp", rsp_valid, 1'b0);

    run(1'b0, 8'h44, 32'h0, 0, 0, 1'b0, rd, er, lat, acc);
    check32("lit_mid_discarded", rd, 32'h1E1E_1E1E);
    run(1'b0, 8'hA5, 32'h0, 1, 0, 1'b0, rd, er, lat, acc);
    check32("lit_final_rd", rd, 32'hDEAD_BEEF);

    repeat (3) @(posedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
